// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and the stall-action encoding used by the pipeline
// boundary registers (ex_mem, mem_wb).
package mem_wb_stage_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // RESET is kept apart from BUBBLE because only reset clears counters.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_RESET  = 2'd3
    } stall_act_e;

endpackage

// File: rtl/mem_wb_stage_pipe_ctl.sv
// Decodes reset, flush and the two stall bits of a pipeline boundary into
// a single stall action; shared by every inter-stage register.
module pipe_ctl
    import mem_wb_stage_pkg::*;
(
    input  logic       rst,
    input  logic       flush,
    input  logic       stall_up,
    input  logic       stall_down,
    output logic [1:0] act
);

    stall_act_e act_d;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        act_d = ACT_HOLD;
        if (rst == RstEnable) begin
            act_d = ACT_RESET;
        end else if (flush) begin
            act_d = ACT_BUBBLE;
        end else if (stall_up && !stall_down) begin
            // Upstream is frozen: downstream must not re-execute its old slot.
            act_d = ACT_BUBBLE;
        end else if (!stall_up && !stall_down) begin
            act_d = ACT_LOAD;
        end
        // stall_up && stall_down holds; the illegal !up && down also holds.
    end

    assign act = act_d;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: carries the GPR, HI/LO and LLbit write bundles
// into WB with stall-hold, bubble and flush, plus a retired-instruction count.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_value,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_llbit_we,
    output logic              wb_llbit_value,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              llbit_we;
        logic              llbit_value;
    } wb_bundle_t;

    logic [1:0] act_raw;
    stall_act_e act;

    wb_bundle_t bundle_d, bundle_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    pipe_ctl u_pipe_ctl (
        .rst        (rst),
        .flush      (flush),
        .stall_up   (stall_mem),
        .stall_down (stall_wb),
        .act        (act_raw)
    );

    assign act = stall_act_e'(act_raw);

    always_comb begin
        bundle_d = bundle_q;
        cnt_d    = cnt_q;
        unique case (act)
            ACT_RESET: begin
                bundle_d = '0;
                cnt_d    = '0;
            end
            ACT_BUBBLE: begin
                bundle_d          = '0;
                bundle_d.wreg     = WriteDisable;
                bundle_d.whilo    = WriteDisable;
                bundle_d.llbit_we = WriteDisable;
            end
            ACT_LOAD: begin
                // Enables pass verbatim; MEM already zeroes them on invalid slots.
                bundle_d.valid       = mem_valid;
                bundle_d.wd          = mem_wd;
                bundle_d.wreg        = mem_wreg;
                bundle_d.wdata       = mem_wdata;
                bundle_d.whilo       = mem_whilo;
                bundle_d.hi          = mem_hi;
                bundle_d.lo          = mem_lo;
                bundle_d.llbit_we    = mem_llbit_we;
                bundle_d.llbit_value = mem_llbit_value;
                if (mem_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is already folded into the _d logic.
    always_ff @(posedge clk) begin
        bundle_q <= bundle_d;
        cnt_q    <= cnt_d;
    end

    assign wb_valid       = bundle_q.valid;
    assign wb_wd          = bundle_q.wd;
    assign wb_wreg        = bundle_q.wreg;
    assign wb_wdata       = bundle_q.wdata;
    assign wb_whilo       = bundle_q.whilo;
    assign wb_hi          = bundle_q.hi;
    assign wb_lo          = bundle_q.lo;
    assign wb_llbit_we    = bundle_q.llbit_we;
    assign wb_llbit_value = bundle_q.llbit_value;
    assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, pass-through, hold, bubble, flush
// priority, counter wrap (CNT_W=4) and mid-stream reset.
module tb_mem_wb_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_mem, stall_wb, flush;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_whilo;
    logic [DATA_W-1:0] mem_hi, mem_lo;
    logic              mem_llbit_we, mem_llbit_value;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi, wb_lo;
    logic              wb_llbit_we, wb_llbit_value;
    logic [CNT_W-1:0]  retired_cnt;

    int checks   = 0;
    int failures = 0;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_mem       (stall_mem),
        .stall_wb        (stall_wb),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_wd          (mem_wd),
        .mem_wreg        (mem_wreg),
        .mem_wdata       (mem_wdata),
        .mem_whilo       (mem_whilo),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_valid        (wb_valid),
        .wb_wd           (wb_wd),
        .wb_wreg         (wb_wreg),
        .wb_wdata        (wb_wdata),
        .wb_whilo        (wb_whilo),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_llbit_we     (wb_llbit_we),
        .wb_llbit_value  (wb_llbit_value),
        .retired_cnt     (retired_cnt)
    );

    always #5 clk = ~clk;

    // ctrl must never stall WB while MEM advances.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(stall_wb && !stall_mem))
                else $error("illegal stall combination stall_mem=0 stall_wb=1");
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle outputs away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic valid, input logic [REG_AW-1:0] wd,
                              input logic wreg, input logic [DATA_W-1:0] wdata);
        mem_valid = valid;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
    endtask

    initial begin
        rst = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
        mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
        mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
        drive_load(1'b1, 5'd3, 1'b1, 32'hDEAD_BEEF);

        // Reset held two cycles with live inputs.
        step(); step();
        check("rst_wdata", wb_wdata, 0);
        check("rst_wreg",  wb_wreg, 0);
        check("rst_wd",    wb_wd, 0);
        check("rst_valid", wb_valid, 0);
        check("rst_cnt",   retired_cnt, 0);

        // Pass-through r3/r4/r5.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_load(1'b1, REG_AW'(3 + i), 1'b1, DATA_W'(1 + i));
            step();
            check("pt_wd",    wb_wd, 3 + i);
            check("pt_wdata", wb_wdata, 1 + i);
            check("pt_wreg",  wb_wreg, 1);
            check("pt_valid", wb_valid, 1);
            check("pt_cnt",   retired_cnt, 1 + i);
        end

        // Load r7/0x55, then hold four cycles while inputs change.
        drive_load(1'b1, 5'd7, 1'b1, 32'h55);
        step();
        check("hold_load_cnt", retired_cnt, 4);
        stall_mem = 1'b1; stall_wb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_load(1'b1, REG_AW'(8 + i), 1'b1, DATA_W'(32'h66 + i));
            step();
            check("hold_wd",    wb_wd, 7);
            check("hold_wdata", wb_wdata, 32'h55);
            check("hold_valid", wb_valid, 1);
            check("hold_cnt",   retired_cnt, 4);
        end

        // Bubble after a valid r9 write.
        stall_mem = 1'b0; stall_wb = 1'b0;
        drive_load(1'b1, 5'd9, 1'b1, 32'h99);
        step();
        check("bub_pre_wd", wb_wd, 9);
        check("bub_pre_cnt", retired_cnt, 5);
        stall_mem = 1'b1;
        step();
        check("bub_wreg",  wb_wreg, 0);
        check("bub_valid", wb_valid, 0);
        check("bub_wd",    wb_wd, 0);
        check("bub_wdata", wb_wdata, 0);
        check("bub_cnt",   retired_cnt, 5);

        // Load HI/LO, then flush with both stalls high.
        stall_mem = 1'b0;
        mem_whilo = 1'b1; mem_hi = 32'hAA; mem_lo = 32'hBB;
        drive_load(1'b1, 5'd0, 1'b0, 32'h0);
        step();
        check("fl_pre_whilo", wb_whilo, 1);
        check("fl_pre_cnt",   retired_cnt, 6);
        flush = 1'b1; stall_mem = 1'b1; stall_wb = 1'b1;
        step();
        check("fl_whilo", wb_whilo, 0);
        check("fl_hi",    wb_hi, 0);
        check("fl_valid", wb_valid, 0);
        check("fl_cnt",   retired_cnt, 6);

        // Normal load with HI/LO and LLbit bundles.
        flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
        mem_hi = 32'h12; mem_lo = 32'h34;
        mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
        step();
        check("hl_whilo",  wb_whilo, 1);
        check("hl_hi",     wb_hi, 32'h12);
        check("hl_lo",     wb_lo, 32'h34);
        check("hl_ll_we",  wb_llbit_we, 1);
        check("hl_ll_val", wb_llbit_value, 1);
        check("hl_cnt",    retired_cnt, 7);

        // Invalid load: bundle still loads verbatim, count unchanged.
        mem_whilo = 1'b0; mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
        drive_load(1'b0, 5'd12, 1'b0, 32'h77);
        step();
        check("inv_valid", wb_valid, 0);
        check("inv_wdata", wb_wdata, 32'h77);
        check("inv_cnt",   retired_cnt, 7);

        // Counter wrap from a fresh reset: 17 valid loads, 4-bit counter.
        rst = 1'b1;
        step();
        check("wrap_rst_cnt", retired_cnt, 0);
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            drive_load(1'b1, 5'd1, 1'b1, DATA_W'(i));
            step();
            check("wrap_cnt", retired_cnt, i % 16);
        end
        drive_load(1'b0, 5'd0, 1'b0, 32'h0);
        step(); step();
        check("wrap_inv_cnt", retired_cnt, 1);

        // Reset mid-stream while holding discards the held slot.
        drive_load(1'b1, 5'd20, 1'b1, 32'hCAFE);
        step();
        check("mid_pre_cnt", retired_cnt, 2);
        stall_mem = 1'b1; stall_wb = 1'b1; rst = 1'b1;
        step();
        check("mid_wd",    wb_wd, 0);
        check("mid_wdata", wb_wdata, 0);
        check("mid_valid", wb_valid, 0);
        check("mid_cnt",   retired_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline boundary between the memory-access stage and the write-back stage of the five-stage core. It carries the GPR write bundle, HI/LO write bundle, LLbit update and a valid flag from MEM to WB. It implements stall-hold, bubble insertion and flush. It also keeps a retired-instruction counter that WB and the performance logic read.

## Interface
Parameters:
- DATA_W, 32, width of GPR/HI/LO data
- REG_AW, 5, GPR address width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_mem  in  1  MEM stage stalled (from ctrl)
- stall_wb  in  1  WB stage stalled (from ctrl)
- flush  in  1  pipeline flush (exception/eret), kills the MEM-stage instruction
- mem_valid  in  1  MEM holds a real instruction
- mem_wd  in  REG_AW  GPR destination address
- mem_wreg  in  1  GPR write enable
- mem_wdata  in  DATA_W  GPR write data
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  DATA_W  HI/LO write data
- mem_llbit_we  in  1  LLbit write enable
- mem_llbit_value  in  1  LLbit value
- wb_valid  out  1  registered copy of mem_valid
- wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_llbit_we, wb_llbit_value  out  (widths as inputs)  registered bundle to WB
- retired_cnt  out  CNT_W  count of instructions loaded into WB

## Operation
Each rising edge applies the first matching rule, in priority order:
1. rst=1: all outputs are 0. This covers wb_wd = all-zero (NOP register), every enable, every data field and retired_cnt.
2. flush=1: insert a bubble. All bundle outputs and wb_valid go to 0; retired_cnt holds.
3. stall_mem=1, stall_wb=0: insert a bubble, same as rule 2. MEM is held, so WB must not re-execute its old instruction.
4. stall_mem=1, stall_wb=1: hold. All outputs keep their values.
5. stall_mem=0, stall_wb=1: illegal combination. ctrl never produces it. The block holds, and the bench flags it with an assertion.
6. stall_mem=0, stall_wb=0: load all mem_* inputs into the wb_* outputs. If mem_valid=1, retired_cnt increments by 1.

Bubble and counter rules:
- A bubble never asserts wb_wreg, wb_whilo or wb_llbit_we.
- retired_cnt wraps modulo 2^CNT_W, from all-ones to 0, with no flag.
- Enables are loaded verbatim; the block does not qualify them with mem_valid. MEM is responsible for zeroing enables on invalid slots.
- Any rule that does not load leaves retired_cnt unchanged.

## Timing
- Latency is 1 cycle from mem_* to wb_*.
- Outputs are purely registered; there is no combinational path from any input to any output.
- The first load is the edge after rst deasserts.
- Flush and stall are sampled on the same edge as the data.
- flush asserted together with a stall still bubbles.
- rst mid-stream discards the held instruction and clears retired_cnt on that edge.

## Structure
- A shared package or defines file holds:
  - RstEnable, WriteEnable, WriteDisable, ZeroWord and NOPRegAddr
  - a stall-action encoding (LOAD, BUBBLE, HOLD)
- Sub-module pipe_ctl: a combinational decode of rst, flush, stall_mem and stall_wb into the stall-action code. ex_mem reuses it with its own stall bits.
- The top level instantiates pipe_ctl, the bundle registers and the retired_cnt counter.

## Test plan
- Reset: drive mem_wdata=32'hDEADBEEF, mem_wreg=1 with rst=1 for 2 cycles -> all outputs 0, retired_cnt=0.
- Pass-through: three valid loads writing r3, r4, r5 with data 1, 2, 3 -> each appears on the next edge; retired_cnt reaches 3.
- Stall hold: load r7/0x55, then stall_mem=stall_wb=1 for 4 cycles while inputs change -> wb_wd=7, wb_wdata=0x55 held; counter unchanged.
- Bubble: stall_mem=1, stall_wb=0 after a valid r9 write -> next cycle wb_wreg=0, wb_valid=0, wb_wd=0; counter unchanged.
- Flush priority: flush=1 with stall_mem=stall_wb=1 and mem_whilo=1 -> bubble, wb_whilo=0. Then 1 normal load -> HI/LO bundle (0x12, 0x34) appears.
- Wrap: CNT_W=4, 17 consecutive valid loads -> retired_cnt reads 15 then 0 then 1. Invalid loads (mem_valid=0) leave the count unchanged.
